das_input_manager: RTL

Parametrised N-channel input conditioner between the debounced keyboard/button decoder and the game-logic FSM. Each channel converts a level "key held" signal into single-cycle command pulses. Channels are either one-shot (one pulse per press) or auto-repeat (delayed auto-shift, DAS). Repeat timing is counted in game frames (`tick_game`), not clocks. A `clear` input locks every channel until its key is released, so a held key cannot leak into the next piece.

---
 rtl/das_input_manager.sv | 121 ++++++++++++
 1 files changed

// File: rtl/das_input_manager.sv
// ============================================================================
// Module   : das_input_manager
// Brief    : N-channel key conditioner producing one-shot or DAS auto-repeat
//            command pulses, frame-timed by tick_game. Optional macro:
//            INPUT_SYNC_EN (2-flop synchronizer on raw).
// Revision : 1.0
// ============================================================================
`default_nettype none

module das_input_manager #(
    parameter int                NUM_CH      = 5,
    parameter logic [NUM_CH-1:0] REPEAT_MASK = 5'b00111,
    parameter int                DAS_DELAY   = 16,
    parameter int                DAS_SPEED   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_game,
    input  logic              clear,
    input  logic [NUM_CH-1:0] raw,
    output logic [NUM_CH-1:0] cmd
);

    localparam int CNT_MAX = (DAS_DELAY > DAS_SPEED) ? DAS_DELAY : DAS_SPEED;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] C_DELAY_LAST = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] C_SPEED_LAST = CNT_W'(DAS_SPEED - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] ST_LOCKED = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_DELAY  = 2'd2;
    localparam logic [1:0] ST_REPEAT = 2'd3;

    logic [NUM_CH-1:0] w_raw;

`ifdef INPUT_SYNC_EN
    logic [NUM_CH-1:0] raw_s1_q;
    logic [NUM_CH-1:0] raw_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_s1_q <= '0;
            raw_s2_q <= '0;
        end else begin
            raw_s1_q <= raw;
            raw_s2_q <= raw_s1_q;
        end
    end

    assign w_raw = raw_s2_q;
`else
    assign w_raw = raw;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             cmd_q, cmd_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            cmd_d   = 1'b0;
            if (clear) begin
                state_d = ST_LOCKED;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_LOCKED: begin
                        if (!w_raw[i]) state_d = ST_IDLE;
                    end
                    ST_IDLE: begin
                        // A press ignores any coincident tick: counter restarts at 0.
                        if (w_raw[i]) begin
                            cmd_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = REPEAT_MASK[i] ? ST_DELAY : ST_LOCKED;
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (!w_raw[i]) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (tick_game) begin
                            if (cnt_q == ((state_q == ST_DELAY) ? C_DELAY_LAST : C_SPEED_LAST)) begin
                                cmd_d   = 1'b1;
                                cnt_d   = '0;
                                state_d = ST_REPEAT;
                            end else begin
                                cnt_d = cnt_q + C_CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_LOCKED;
                cnt_q   <= '0;
                cmd_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                cmd_q   <= cmd_d;
            end
        end

        assign cmd[i] = cmd_q;
    end

endmodule

`default_nettype wire
